i2c_slave_responder: RTL and testbench
======================================

Name: i2c_slave_responder

Overview:
- I2C target (slave) for the system I2C bus; the bus-side counterpart of the I2C master read controller.
- Oversamples SCL/SDA on the system clock and detects START/STOP conditions.
- Matches a 7-bit address and ACKs it, then either shifts out bytes supplied by local logic (master read) or captures bytes into a local register (master write), ACKing each one.
- SDA is open-drain: sda_oe=1 pulls SDA low; sda_oe=0 releases it.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit bus address this block responds to.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  raw bus SCL, asynchronous to clk.
- sda  input  1  raw bus SDA, asynchronous to clk.
- sda_oe  output  1  1 = drive SDA low, 0 = release.
- tx_data  input  8  byte to return on a master read; sampled when tx_req pulses.
- tx_req  output  1  one-cycle pulse: tx_data latched; local logic presents the next byte before the next tx_req.
- rx_data  output  8  last byte received in a master write.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high from address match until STOP, START, or NACK-end of a read.

Behaviour:
- Reset (async, active-high): sda_oe=0, tx_req=0, rx_data=8'h00, rx_valid=0, busy=0, state=IDLE, bit counter=0, synchronizer flops=1.
- Synchronization:
  - scl and sda each pass through a 2-flop synchronizer, plus a third delayed flop for edge detection.
  - Edges are detected when stage 2 differs from stage 3.
  - The bus must hold each SCL phase for at least 4 clk cycles.
- Bus events, evaluated every cycle on synced signals:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - START and STOP take priority over all states.
  - START: state→ADDR, bit counter=7, sda_oe=0, busy=0.
  - STOP: state→IDLE, sda_oe=0, busy=0.
- Sampling and driving:
  - Data is sampled on the synced SCL rising edge.
  - sda_oe changes only on the synced SCL falling edge, registered in that cycle.
- States:
  - IDLE: sda_oe=0; waits for START.
  - ADDR: shift in 8 bits MSB first (7 address bits + R/W).
    - On the 8th rising edge, if addr==SLAVE_ADDR: latch R/W, busy=1, →ADDR_ACK.
    - Otherwise →IDLE, never drive SDA, and ignore the bus until the next START.
  - ADDR_ACK:
    - 1st falling edge: sda_oe=1.
    - Next falling edge (after the 9th rise): if R/W=1, latch tx_data into the shifter, pulse tx_req, drive ~bit7, →TX with counter=7.
    - If R/W=0: sda_oe=0, →RX with counter=7.
  - TX:
    - Each falling edge: drive ~shift[counter] and decrement.
    - After bit 0's rising edge: at the next falling edge sda_oe=0 (release for master ACK), →TX_ACK.
  - TX_ACK: on the rising edge, sample SDA.
    - SDA=0 (ACK): at the next falling edge latch tx_data, pulse tx_req, drive ~bit7, →TX.
    - SDA=1 (NACK): busy=0, →IDLE with sda_oe=0.
  - RX:
    - Each rising edge: shift in SDA.
    - On the 8th rising edge: rx_data←byte, rx_valid pulses 1 cycle, →RX_ACK.
  - RX_ACK: falling edge sda_oe=1; after the 9th rise, next falling edge sda_oe=0, →RX with counter=7.
- Boundary conditions:
  - Repeated START mid-byte: aborts the current byte, no rx_valid, and addressing restarts.
  - STOP mid-byte: discards partial data.
  - The slave never holds SDA low across a START/STOP detection; sda_oe is cleared on detection.
  - No clock stretching; SCL is never driven.
  - The tx_data byte for the first read byte is latched at the ADDR_ACK→TX transition.
  - Reset asserted mid-transfer returns all outputs to reset values immediately, including releasing SDA.

Test Plan:
- Write: START, addr 0x42+W, byte 0xA5, STOP → ACK on the 9th clock of both bytes; rx_data=0xA5, rx_valid high exactly 1 cycle; busy 1→0 at STOP.
- Read, 2 bytes: START, 0x42+R, tx_data=0x3C then 0xC3, master ACK then NACK → bus sees 0x3C, 0xC3 MSB first; tx_req pulses twice; after NACK sda_oe=0, busy=0.
- Address mismatch: START, 0x43+W, byte 0xFF → sda_oe stays 0 throughout; no rx_valid; busy stays 0.
- Repeated START: write 0x42+W, 4 bits of data, then START and 0x42+R → no rx_valid; a new ACK occurs; read returns tx_data.
- STOP mid-byte: 0x42+W, 5 data bits, STOP → state IDLE, rx_data unchanged, sda_oe=0.
- Reset while the slave is driving ACK (sda_oe=1) → sda_oe=0 within the same cycle as rst; all outputs at reset values; the next full write transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// I2C target: ACKs SLAVE_ADDR, streams tx_data on master reads, captures rx_data on master writes.
// Latency: bus edges act 3 clk after the pins (2-flop sync + edge flop); no backpressure, never stretches SCL.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, TX, TX_ACK, RX, RX_ACK} state_t;

  state_t     state, state_nxt;
  logic [2:0] scl_sync, sda_sync;
  logic [2:0] bit_cnt, bit_cnt_nxt, cnt_dec;
  logic [1:0] phase, phase_nxt;
  logic [7:0] shift, shift_nxt, rx_data_nxt;
  logic       rw, rw_nxt;
  logic       sda_oe_nxt, tx_req_nxt, rx_valid_nxt, busy_nxt, load_tx;
  logic       scl_rise, scl_fall, bus_start, bus_stop, sda_in;

  // Index [1] is the synchronized level, [2] the previous one for edge detection.
  assign scl_rise  = scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] & scl_sync[2];
  assign sda_in    = sda_sync[1];
  assign bus_start = scl_sync[1] & scl_sync[2] & ~sda_sync[1] & sda_sync[2];
  assign bus_stop  = scl_sync[1] & scl_sync[2] & sda_sync[1] & ~sda_sync[2];
  assign cnt_dec   = bit_cnt - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl};
      sda_sync <= {sda_sync[1:0], sda};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      phase    <= 2'd0;
      shift    <= 8'h00;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      tx_req   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      phase    <= phase_nxt;
      shift    <= shift_nxt;
      rw       <= rw_nxt;
      sda_oe   <= sda_oe_nxt;
      tx_req   <= tx_req_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      busy     <= busy_nxt;
    end
  end

  // phase: in ACK states 0 = wait first fall, 1 = wait 9th rise, 2 = wait final fall.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    phase_nxt    = phase;
    shift_nxt    = shift;
    rw_nxt       = rw;
    sda_oe_nxt   = sda_oe;
    tx_req_nxt   = 1'b0;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    busy_nxt     = busy;
    load_tx      = 1'b0;
    if (bus_start) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 3'd7;
      phase_nxt   = 2'd0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else if (bus_stop) begin
      state_nxt  = IDLE;
      phase_nxt  = 2'd0;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: sda_oe_nxt = 1'b0;
        ADDR: begin
          if (scl_rise) begin
            shift_nxt = {shift[6:0], sda_in};
            if (bit_cnt == 3'd0) begin
              if (shift[6:0] == SLAVE_ADDR) begin
                rw_nxt    = sda_in;
                busy_nxt  = 1'b1;
                phase_nxt = 2'd0;
                state_nxt = ADDR_ACK;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              bit_cnt_nxt = cnt_dec;
            end
          end
        end
        ADDR_ACK, RX_ACK: begin
          if (phase == 2'd0 && scl_fall) begin
            sda_oe_nxt = 1'b1;
            phase_nxt  = 2'd1;
          end else if (phase == 2'd1 && scl_rise) begin
            phase_nxt = 2'd2;
          end else if (phase == 2'd2 && scl_fall) begin
            if (state == ADDR_ACK && rw) begin
              load_tx = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 3'd7;
              phase_nxt   = 2'd0;
              state_nxt   = RX;
            end
          end
        end
        TX: begin
          if (scl_rise && bit_cnt == 3'd0) begin
            phase_nxt = 2'd1;
          end else if (scl_fall) begin
            if (phase == 2'd1) begin
              sda_oe_nxt = 1'b0;
              phase_nxt  = 2'd0;
              state_nxt  = TX_ACK;
            end else begin
              bit_cnt_nxt = cnt_dec;
              sda_oe_nxt  = ~shift[cnt_dec];
            end
          end
        end
        TX_ACK: begin
          if (phase == 2'd0 && scl_rise) begin
            if (!sda_in) begin
              phase_nxt = 2'd1;
            end else begin
              busy_nxt   = 1'b0;
              sda_oe_nxt = 1'b0;
              state_nxt  = IDLE;
            end
          end else if (phase == 2'd1 && scl_fall) begin
            load_tx = 1'b1;
          end
        end
        RX: begin
          if (scl_rise) begin
            shift_nxt = {shift[6:0], sda_in};
            if (bit_cnt == 3'd0) begin
              rx_data_nxt  = {shift[6:0], sda_in};
              rx_valid_nxt = 1'b1;
              phase_nxt    = 2'd0;
              state_nxt    = RX_ACK;
            end else begin
              bit_cnt_nxt = cnt_dec;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (load_tx) begin
        shift_nxt   = tx_data;
        tx_req_nxt  = 1'b1;
        sda_oe_nxt  = ~tx_data[7];
        bit_cnt_nxt = 3'd7;
        phase_nxt   = 2'd0;
        state_nxt   = TX;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: an I2C master model on a wired-AND SDA line drives write, read, mismatch and abort scenarios.
module tb_i2c_slave_responder;

  localparam int Q = 6;

  logic       clk, rst, scl_m, sda_m, sda_bus;
  logic       sda_oe, tx_req, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
  int         total, bad;
  int         n_rxv, n_txr, n_oe, n_busy;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_responder #(.SLAVE_ADDR(7'h42)) dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda(sda_bus), .sda_oe(sda_oe),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) n_rxv++;
    if (tx_req) n_txr++;
    if (sda_oe) n_oe++;
    if (busy) n_busy++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b1; wait_cyc(Q);
  endtask

  // One SCL clock; s is the bus level sampled mid-high.
  task automatic send_bit(input logic b, output logic s);
    sda_m = b;    wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    s = sda_bus;  wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      d = {d[6:0], s};
    end
    send_bit(master_ack, s);
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_cyc(4);
    rst = 1'b0; wait_cyc(4);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic ack;
    int   rxv0;
    rxv0 = n_rxv;
    bus_start();
    write_byte(8'h84, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL write_addr_ack: got %b want 0", ack); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy: got %b want 1", busy); end
    write_byte(8'hA5, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL write_data_ack: got %b want 0", ack); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL write_rx_data: got %h want a5", rx_data); end
    total++; if (n_rxv - rxv0 !== 1) begin bad++; $display("FAIL write_rx_valid_cycles: got %0d want 1", n_rxv - rxv0); end
    bus_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL write_oe_after_stop: got %b want 0", sda_oe); end
  endtask

  task automatic test_read();
    logic       ack;
    logic [7:0] d;
    int         txr0;
    txr0 = n_txr;
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'h85, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL read_addr_ack: got %b want 0", ack); end
    total++; if (n_txr - txr0 !== 1) begin bad++; $display("FAIL read_first_tx_req: got %0d want 1", n_txr - txr0); end
    tx_data = 8'hC3;
    read_byte(1'b0, d);
    total++; if (d !== 8'h3C) begin bad++; $display("FAIL read_byte0: got %h want 3c", d); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy: got %b want 1", busy); end
    read_byte(1'b1, d);
    total++; if (d !== 8'hC3) begin bad++; $display("FAIL read_byte1: got %h want c3", d); end
    total++; if (n_txr - txr0 !== 2) begin bad++; $display("FAIL read_tx_req_count: got %0d want 2", n_txr - txr0); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL read_oe_after_nack: got %b want 0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_after_nack: got %b want 0", busy); end
    bus_stop();
  endtask

  task automatic test_mismatch();
    logic ack;
    int   oe0, rxv0, busy0;
    oe0 = n_oe; rxv0 = n_rxv; busy0 = n_busy;
    bus_start();
    write_byte(8'h86, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL mismatch_addr_ack: got %b want 1", ack); end
    write_byte(8'hFF, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL mismatch_data_ack: got %b want 1", ack); end
    bus_stop();
    total++; if (n_oe - oe0 !== 0) begin bad++; $display("FAIL mismatch_oe_cycles: got %0d want 0", n_oe - oe0); end
    total++; if (n_rxv - rxv0 !== 0) begin bad++; $display("FAIL mismatch_rx_valid: got %0d want 0", n_rxv - rxv0); end
    total++; if (n_busy - busy0 !== 0) begin bad++; $display("FAIL mismatch_busy_cycles: got %0d want 0", n_busy - busy0); end
  endtask

  task automatic test_repeated_start();
    logic       ack, s;
    logic [7:0] d;
    int         rxv0;
    rxv0 = n_rxv;
    tx_data = 8'h5A;
    bus_start();
    write_byte(8'h84, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rstart_first_ack: got %b want 0", ack); end
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
    bus_start();
    write_byte(8'h85, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rstart_second_ack: got %b want 0", ack); end
    read_byte(1'b1, d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL rstart_read: got %h want 5a", d); end
    total++; if (n_rxv - rxv0 !== 0) begin bad++; $display("FAIL rstart_rx_valid: got %0d want 0", n_rxv - rxv0); end
    bus_stop();
  endtask

  task automatic test_stop_mid_byte();
    logic ack, s;
    int   rxv0;
    rxv0 = n_rxv;
    bus_start();
    write_byte(8'h84, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL stopmid_ack: got %b want 0", ack); end
    for (int i = 0; i < 5; i++) send_bit(i[0], s);
    bus_stop();
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL stopmid_rx_data: got %h want a5", rx_data); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL stopmid_oe: got %b want 0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stopmid_busy: got %b want 0", busy); end
    total++; if (n_rxv - rxv0 !== 0) begin bad++; $display("FAIL stopmid_rx_valid: got %0d want 0", n_rxv - rxv0); end
  endtask

  task automatic test_reset_mid_ack();
    logic       ack, s;
    logic [7:0] a;
    a = 8'h84;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(a[i], s);
    sda_m = 1'b1;
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rstmid_driving_ack: got %b want 1", sda_oe); end
    #3 rst = 1'b1;
    #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rstmid_oe: got %b want 0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
    total++; if ({tx_req, rx_valid} !== 2'b00) begin bad++; $display("FAIL rstmid_pulses: got %b want 00", {tx_req, rx_valid}); end
    wait_cyc(2);
    scl_m = 1'b1;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(4);
    bus_start();
    write_byte(8'h84, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rstmid_again_addr_ack: got %b want 0", ack); end
    write_byte(8'h96, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rstmid_again_data_ack: got %b want 0", ack); end
    total++; if (rx_data !== 8'h96) begin bad++; $display("FAIL rstmid_again_rx_data: got %h want 96", rx_data); end
    bus_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_again_busy: got %b want 0", busy); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    total = 0; bad = 0; n_rxv = 0; n_txr = 0; n_oe = 0; n_busy = 0;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_stop_mid_byte();
    test_reset_mid_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
